ibex_prefetch_buffer_mo: RTL and testbench

// - Word-fetch prefetch buffer between the IF stage and the instruction bus. Supports a

---
 rtl/ibex_prefetch_buffer_mo_pkg.sv | 29 ++
 rtl/ibex_prefetch_buffer_mo_if.sv | 41 ++++
 rtl/ibex_prefetch_buffer_mo_fifo.sv | 74 +++++++
 rtl/ibex_prefetch_buffer_mo.sv | 179 +++++++++++++++++
 tb/tb_ibex_prefetch_buffer_mo.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_prefetch_buffer_mo_pkg.sv
// Shared types and helpers for the multi-outstanding prefetch buffer.
// Holds the FIFO entry layout, the request-state encoding and the address helpers.
package ibex_prefetch_buffer_mo_pkg;

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] addr;
      logic        err;
   } fetch_entry_t;

   // A held request that lived through a branch must have its response dropped later.
   typedef enum logic [1:0] {
      ReqIdle      = 2'd0,
      ReqHeld      = 2'd1,
      ReqHeldStale = 2'd2
   } req_state_e;

   localparam int unsigned DefaultNumReqs   = 2;
   localparam int unsigned DefaultFifoDepth = 3;

   function automatic int unsigned cnt_width(int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic logic [31:0] word_align(logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/ibex_prefetch_buffer_mo_if.sv
// Core-side and instruction-bus-side signals of the prefetch buffer.
// The master modport is the buffer's view; slave is the view of the core and bus.
interface ibex_prefetch_buffer_mo_if
   import ibex_prefetch_buffer_mo_pkg::*;
#(
   parameter int unsigned FifoDepth = DefaultFifoDepth
);
   localparam int unsigned CntW = cnt_width(FifoDepth);

   logic            req_i;
   logic            branch_i;
   logic [31:0]     addr_i;
   logic            ready_i;
   logic            valid_o;
   logic [31:0]     rdata_o;
   logic [31:0]     addr_o;
   logic            err_o;
   logic [CntW-1:0] level_o;
   logic            instr_req_o;
   logic            instr_gnt_i;
   logic [31:0]     instr_addr_o;
   logic [31:0]     instr_rdata_i;
   logic            instr_err_i;
   logic            instr_rvalid_i;
   logic            busy_o;

   modport master (
      input  req_i, branch_i, addr_i, ready_i,
      input  instr_gnt_i, instr_rdata_i, instr_err_i, instr_rvalid_i,
      output valid_o, rdata_o, addr_o, err_o, level_o,
      output instr_req_o, instr_addr_o, busy_o
   );

   modport slave (
      output req_i, branch_i, addr_i, ready_i,
      output instr_gnt_i, instr_rdata_i, instr_err_i, instr_rvalid_i,
      input  valid_o, rdata_o, addr_o, err_o, level_o,
      input  instr_req_o, instr_addr_o, busy_o
   );

endinterface

// File: rtl/ibex_prefetch_buffer_mo_fifo.sv
// Synchronous FIFO of fetched words with a flush input and an occupancy output.
// Pointers wrap at Depth, so non-power-of-two depths work.
module ibex_prefetch_buffer_mo_fifo #(
   parameter int unsigned Depth = 3,
   parameter type T = logic [31:0],
   localparam int unsigned LvlW = $clog2(Depth + 1),
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clear_i,
   input  logic            push_i,
   input  T                data_i,
   input  logic            pop_i,
   output T                data_o,
   output logic            valid_o,
   output logic [LvlW-1:0] level_o
);

   T                mem [Depth];
   logic [PtrW-1:0] rd_ptr_q;
   logic [PtrW-1:0] wr_ptr_q;
   logic [LvlW-1:0] level_q;
   logic            push_en;
   logic            pop_en;

   function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
   endfunction

   always_comb begin
      push_en = push_i & ~clear_i;
      pop_en  = pop_i & ~clear_i & (level_q != '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_en) begin
            wr_ptr_q <= next_ptr(wr_ptr_q);
         end
         if (pop_en) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         level_q <= level_q + LvlW'(push_en) - LvlW'(pop_en);
      end
   end

   // Storage needs no reset: entries are only visible once level counts them.
   always_ff @(posedge clk_i) begin
      if (!rst_i && push_en) begin
         mem[wr_ptr_q] <= data_i;
      end
   end

   always_comb begin
      data_o  = mem[rd_ptr_q];
      valid_o = (level_q != '0);
      level_o = level_q;
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(push_en && !pop_en && level_q == LvlW'(Depth)))
            else $error("prefetch fifo pushed while full");
      end
   end
`endif

endmodule

// File: rtl/ibex_prefetch_buffer_mo.sv
// Word-fetch prefetch buffer with several outstanding bus requests and discard counting on branch.
// A bus error stops new fetches until the next branch; FIFO occupancy is exported.
module ibex_prefetch_buffer_mo
   import ibex_prefetch_buffer_mo_pkg::*;
#(
   parameter int unsigned NumReqs   = DefaultNumReqs,
   parameter int unsigned FifoDepth = DefaultFifoDepth
) (
   input logic                       clk_i,
   input logic                       rst_i,
   ibex_prefetch_buffer_mo_if.master bus
);

   localparam int unsigned CntW = cnt_width(FifoDepth);
   localparam int unsigned SumW = CntW + 1;

   req_state_e      req_state_q;
   logic [31:0]     stored_addr_q;
   logic [31:0]     fetch_addr_q;
   logic [31:0]     push_addr_q;
   logic [CntW-1:0] out_cnt_q;
   logic [CntW-1:0] disc_cnt_q;
   logic            err_halt_q;

   logic [CntW-1:0] level;
   logic [SumW-1:0] occupancy;
   logic [SumW-1:0] disc_branch;
   logic [CntW-1:0] out_cnt_d;
   logic [CntW-1:0] disc_cnt_d;
   logic [31:0]     branch_addr;
   logic [31:0]     new_addr;
   logic [31:0]     req_addr;
   logic            held;
   logic            held_stale;
   logic            room;
   logic            issue;
   logic            instr_req;
   logic            grant;
   logic            rvalid;
   logic            drop;
   logic            push;
   logic            pop;
   logic            head_valid;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   always_comb begin
      held        = (req_state_q != ReqIdle);
      held_stale  = (req_state_q == ReqHeldStale);
      occupancy   = {1'b0, level} + {1'b0, out_cnt_q};
      room        = (occupancy < SumW'(FifoDepth));
      issue       = ~rst_i & bus.req_i & ~held & ~err_halt_q &
                    (out_cnt_q < CntW'(NumReqs)) & (room | bus.branch_i);
      branch_addr = word_align(bus.addr_i);
      new_addr    = bus.branch_i ? branch_addr : fetch_addr_q;
      req_addr    = held ? stored_addr_q : new_addr;
      instr_req   = ~rst_i & (held | issue);
      grant       = instr_req & bus.instr_gnt_i;
      rvalid      = ~rst_i & bus.instr_rvalid_i & (out_cnt_q != '0);
      drop        = rvalid & (disc_cnt_q != '0);
      push        = rvalid & (disc_cnt_q == '0) & ~bus.branch_i;
      pop         = head_valid & bus.ready_i;
   end

   // On a branch every response still owed belongs to the old stream, including a held
   // request granted in that very cycle; a request issued in the branch cycle is kept.
   always_comb begin
      out_cnt_d   = out_cnt_q + CntW'(grant) - CntW'(rvalid);
      disc_branch = {1'b0, out_cnt_q} - SumW'(rvalid) + SumW'(held & bus.instr_gnt_i);
      if (bus.branch_i) begin
         disc_cnt_d = (disc_branch > SumW'(NumReqs)) ? CntW'(NumReqs) : disc_branch[CntW-1:0];
      end else begin
         disc_cnt_d = disc_cnt_q - CntW'(drop) + CntW'(held_stale & bus.instr_gnt_i);
      end
   end

   always_comb begin
      push_entry.rdata = bus.instr_rdata_i;
      push_entry.addr  = push_addr_q;
      push_entry.err   = bus.instr_err_i;
   end

   ibex_prefetch_buffer_mo_fifo #(
      .Depth (FifoDepth),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (bus.branch_i),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (head),
      .valid_o (head_valid),
      .level_o (level)
   );

   // Request FSM plus counters and address registers. push_addr follows the sequential
   // stream from the branch target, since only non-discarded responses advance it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_state_q   <= ReqIdle;
         stored_addr_q <= '0;
         fetch_addr_q  <= '0;
         push_addr_q   <= '0;
         out_cnt_q     <= '0;
         disc_cnt_q    <= '0;
         err_halt_q    <= 1'b0;
      end else begin
         out_cnt_q  <= out_cnt_d;
         disc_cnt_q <= disc_cnt_d;

         case (req_state_q)
            ReqIdle: begin
               if (issue && !bus.instr_gnt_i) begin
                  req_state_q   <= ReqHeld;
                  stored_addr_q <= new_addr;
               end
            end
            ReqHeld: begin
               if (bus.instr_gnt_i) begin
                  req_state_q <= ReqIdle;
               end else if (bus.branch_i) begin
                  req_state_q <= ReqHeldStale;
               end
            end
            ReqHeldStale: begin
               if (bus.instr_gnt_i) begin
                  req_state_q <= ReqIdle;
               end
            end
            default: req_state_q <= ReqIdle;
         endcase

         if (bus.branch_i) begin
            fetch_addr_q <= issue ? branch_addr + 32'd4 : branch_addr;
         end else if (issue) begin
            fetch_addr_q <= fetch_addr_q + 32'd4;
         end

         if (bus.branch_i) begin
            push_addr_q <= branch_addr;
         end else if (push) begin
            push_addr_q <= push_addr_q + 32'd4;
         end

         if (bus.branch_i) begin
            err_halt_q <= 1'b0;
         end else if (push && bus.instr_err_i) begin
            err_halt_q <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.valid_o      = head_valid;
      bus.rdata_o      = head_valid ? head.rdata : '0;
      bus.addr_o       = head_valid ? head.addr : '0;
      bus.err_o        = head_valid & head.err;
      bus.level_o      = level;
      bus.instr_req_o  = instr_req;
      bus.instr_addr_o = instr_req ? req_addr : '0;
      bus.busy_o       = instr_req | (out_cnt_q != '0);
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(bus.instr_rvalid_i && out_cnt_q == '0))
            else $error("rvalid with no outstanding request");
         assert (out_cnt_q <= CntW'(NumReqs))
            else $error("outstanding count above NumReqs");
         assert (disc_cnt_q <= out_cnt_q)
            else $error("discard count above outstanding count");
      end
   end
`endif

endmodule

// File: tb/tb_ibex_prefetch_buffer_mo.sv
// Self-checking bench: a bus model answers in order, a scoreboard predicts every word popped.
// Directed sequences cover streaming, backpressure, flushes, held requests and bus errors.
module tb_ibex_prefetch_buffer_mo;
   import ibex_prefetch_buffer_mo_pkg::*;

   localparam int unsigned NumReqs   = 2;
   localparam int unsigned FifoDepth = 3;

   typedef struct {
      logic [31:0] addr;
      bit          stale;
   } pend_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   ibex_prefetch_buffer_mo_if #(.FifoDepth(FifoDepth)) bus ();

   ibex_prefetch_buffer_mo #(
      .NumReqs   (NumReqs),
      .FifoDepth (FifoDepth)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int unsigned  tests_run    = 0;
   int unsigned  tests_failed = 0;
   pend_t        pend [$];
   fetch_entry_t sb   [$];
   bit           gnt_en, rsp_en, tb_held, cur_stale, got_first_gnt, got_first_pop;
   logic [31:0]  err_addr, exp_addr, first_gnt_addr, first_pop_addr, err_pop_addr;
   int unsigned  err_seen, grants, req_cycles;
   logic         s_req, s_valid, s_busy, s_grant;
   logic [31:0]  s_addr, s_head_addr, s_level;

   function automatic logic [31:0] memWord(logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   task automatic checkOutput(string tag, logic [31:0] actual, logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // One clock cycle: bus model drives at the negedge, outputs are sampled 1 time unit later,
   // then the scoreboard and the pending-response model are updated for the coming edge.
   task automatic applyStimulus();
      fetch_entry_t exp_e;
      pend_t        p;
      bit           is_branch;
      bit           stale;
      @(negedge clk_i);
      bus.instr_gnt_i = gnt_en;
      if (rsp_en && pend.size() > 0) begin
         bus.instr_rvalid_i = 1'b1;
         bus.instr_rdata_i  = memWord(pend[0].addr);
         bus.instr_err_i    = (pend[0].addr == err_addr);
      end else begin
         bus.instr_rvalid_i = 1'b0;
         bus.instr_rdata_i  = '0;
         bus.instr_err_i    = 1'b0;
      end
      #1;
      s_req       = bus.instr_req_o;
      s_addr      = bus.instr_addr_o;
      s_valid     = bus.valid_o;
      s_head_addr = bus.addr_o;
      s_level     = 32'(bus.level_o);
      s_busy      = bus.busy_o;
      s_grant     = !rst_i && s_req && gnt_en;
      is_branch   = !rst_i && bus.branch_i;

      if (rst_i) begin
         pend.delete();
         sb.delete();
         tb_held   = 1'b0;
         cur_stale = 1'b0;
      end else begin
         if (s_valid && bus.ready_i && !is_branch) begin
            if (sb.size() == 0) begin
               checkOutput("pop_with_empty_scoreboard", 32'(s_valid), 32'd0);
            end else begin
               exp_e = sb.pop_front();
               checkOutput("pop_rdata", bus.rdata_o, exp_e.rdata);
               checkOutput("pop_addr", bus.addr_o, exp_e.addr);
               checkOutput("pop_err", 32'(bus.err_o), 32'(exp_e.err));
            end
            if (!got_first_pop) begin
               got_first_pop  = 1'b1;
               first_pop_addr = bus.addr_o;
            end
            if (bus.err_o) begin
               err_seen++;
               err_pop_addr = bus.addr_o;
            end
         end
         if (is_branch) begin
            sb.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            if (tb_held) cur_stale = 1'b1;
            exp_addr       = {bus.addr_i[31:2], 2'b00};
            got_first_gnt  = 1'b0;
            got_first_pop  = 1'b0;
            first_gnt_addr = 32'hDEAD_0000;
            first_pop_addr = 32'hDEAD_0000;
         end
         if (bus.instr_rvalid_i && pend.size() > 0) begin
            p = pend.pop_front();
            if (!p.stale && !is_branch) begin
               sb.push_back('{rdata: memWord(exp_addr), addr: exp_addr, err: (exp_addr == err_addr)});
               exp_addr += 32'd4;
            end
         end
         if (s_grant) begin
            stale = tb_held ? cur_stale : 1'b0;
            pend.push_back('{addr: s_addr, stale: stale});
            if (!stale && !got_first_gnt) begin
               got_first_gnt  = 1'b1;
               first_gnt_addr = s_addr;
            end
            tb_held   = 1'b0;
            cur_stale = 1'b0;
         end else if (s_req) begin
            if (!tb_held) cur_stale = 1'b0;
            tb_held = 1'b1;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic drainAll(string tag);
      bus.req_i    = 1'b0;
      bus.branch_i = 1'b0;
      bus.ready_i  = 1'b1;
      gnt_en       = 1'b1;
      rsp_en       = 1'b1;
      for (int i = 0; i < 40; i++) begin
         applyStimulus();
         if (pend.size() == 0 && !tb_held && !s_req && !s_valid && i > 2) break;
      end
      checkOutput({tag, "_scoreboard_empty"}, sb.size(), 32'd0);
      checkOutput({tag, "_level_zero"}, 32'(bus.level_o), 32'd0);
   endtask

   task automatic branchTo(logic [31:0] target);
      bus.branch_i = 1'b1;
      bus.addr_i   = target;
      bus.req_i    = 1'b1;
      applyStimulus();
      bus.branch_i = 1'b0;
   endtask

   initial begin
      bus.req_i = 1'b1; bus.branch_i = 1'b0; bus.addr_i = '0; bus.ready_i = 1'b0;
      bus.instr_gnt_i = 1'b0; bus.instr_rdata_i = '0; bus.instr_err_i = 1'b0;
      bus.instr_rvalid_i = 1'b0;
      gnt_en = 1'b0; rsp_en = 1'b0; tb_held = 1'b0; cur_stale = 1'b0;
      err_addr = 32'h1; exp_addr = '0; err_seen = 0;
      got_first_gnt = 1'b0; got_first_pop = 1'b0;
      first_gnt_addr = '0; first_pop_addr = '0; err_pop_addr = '0;

      // Reset, with req_i high to show nothing leaks out
      rst_i = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("reset_instr_req", 32'(s_req), 32'd0);
      checkOutput("reset_valid", 32'(s_valid), 32'd0);
      checkOutput("reset_level", s_level, 32'd0);
      checkOutput("reset_busy", 32'(s_busy), 32'd0);
      rst_i = 1'b0;
      bus.req_i = 1'b0;
      applyStimulus();
      checkOutput("idle_instr_req", 32'(s_req), 32'd0);
      checkOutput("idle_valid", 32'(s_valid), 32'd0);

      // Streaming from 0x100
      gnt_en = 1'b1; rsp_en = 1'b1; bus.ready_i = 1'b1;
      branchTo(32'h100);
      checkOutput("stream_first_req_addr", s_addr, 32'h100);
      applyStimulus();
      checkOutput("stream_valid_latency", 32'(s_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("stream_back_to_back_valid", 32'(s_valid), 32'd1);
         checkOutput("stream_head_addr", s_head_addr, 32'h100 + 32'(4 * i));
      end
      drainAll("stream");

      // Backpressure fills the FIFO; one pop allows exactly one more request
      gnt_en = 1'b1; rsp_en = 1'b1; bus.ready_i = 1'b0;
      grants = 0;
      branchTo(32'h180);
      if (s_grant) grants++;
      for (int i = 0; i < 7; i++) begin
         applyStimulus();
         if (s_grant) grants++;
      end
      checkOutput("full_grant_count", grants, 32'd3);
      checkOutput("full_instr_req_low", 32'(s_req), 32'd0);
      checkOutput("full_level", s_level, 32'd3);
      grants = 0;
      bus.ready_i = 1'b1;
      applyStimulus();
      if (s_grant) grants++;
      bus.ready_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus();
         if (s_grant) grants++;
      end
      checkOutput("refill_grant_count", grants, 32'd1);
      checkOutput("refill_level", s_level, 32'd3);
      drainAll("full");

      // Branch with two outstanding requests (0x10, 0x14)
      gnt_en = 1'b1; rsp_en = 1'b0; bus.ready_i = 1'b1;
      branchTo(32'h10);
      applyStimulus();
      applyStimulus();
      checkOutput("outstanding_two_req_low", 32'(s_req), 32'd0);
      branchTo(32'h200);
      checkOutput("discard_count_after_branch", 32'(dut.disc_cnt_q), 32'd2);
      rsp_en = 1'b1;
      for (int i = 0; i < 10; i++) applyStimulus();
      checkOutput("discard_first_gnt_addr", first_gnt_addr, 32'h200);
      checkOutput("discard_first_pop_addr", first_pop_addr, 32'h200);
      checkOutput("discard_count_returns_zero", 32'(dut.disc_cnt_q), 32'd0);
      drainAll("discard");

      // Branch while the request to 0x40 is held ungranted
      gnt_en = 1'b0; rsp_en = 1'b1; bus.ready_i = 1'b1;
      branchTo(32'h40);
      applyStimulus();
      checkOutput("held_req_high", 32'(s_req), 32'd1);
      checkOutput("held_addr_before_branch", s_addr, 32'h40);
      branchTo(32'h300);
      checkOutput("held_addr_in_branch", s_addr, 32'h40);
      applyStimulus();
      checkOutput("held_addr_after_branch", s_addr, 32'h40);
      gnt_en = 1'b1;
      for (int i = 0; i < 10; i++) applyStimulus();
      checkOutput("held_next_gnt_addr", first_gnt_addr, 32'h300);
      checkOutput("held_first_pop_addr", first_pop_addr, 32'h300);
      drainAll("held");

      // Bus error on 0x80 halts fetching until the next branch
      gnt_en = 1'b1; rsp_en = 1'b1; bus.ready_i = 1'b1;
      err_addr = 32'h80; err_seen = 0;
      branchTo(32'h78);
      for (int i = 0; i < 10; i++) applyStimulus();
      req_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus();
         if (s_req) req_cycles++;
      end
      checkOutput("error_halts_requests", req_cycles, 32'd0);
      checkOutput("error_entry_count", err_seen, 32'd1);
      checkOutput("error_entry_addr", err_pop_addr, 32'h80);
      err_addr = 32'h1;
      branchTo(32'h400);
      for (int i = 0; i < 10; i++) applyStimulus();
      checkOutput("error_resume_gnt_addr", first_gnt_addr, 32'h400);
      checkOutput("error_resume_pop_addr", first_pop_addr, 32'h400);
      drainAll("error");

      // Branch, rvalid and grant of a held request all in one cycle
      gnt_en = 1'b1; rsp_en = 1'b0; bus.ready_i = 1'b1;
      branchTo(32'h500);
      gnt_en = 1'b0;
      applyStimulus();
      checkOutput("combo_held_req", 32'(s_req), 32'd1);
      gnt_en = 1'b1; rsp_en = 1'b1;
      branchTo(32'h600);
      checkOutput("combo_disc_cnt", 32'(dut.disc_cnt_q), 32'd1);
      checkOutput("combo_out_cnt", 32'(dut.out_cnt_q), 32'd1);
      for (int i = 0; i < 12; i++) applyStimulus();
      checkOutput("combo_first_gnt_addr", first_gnt_addr, 32'h600);
      checkOutput("combo_first_pop_addr", first_pop_addr, 32'h600);
      drainAll("combo");
      checkOutput("final_busy", 32'(bus.busy_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
